// File: rtl/frame_dump_pkg.sv
// Shared definitions for the frame dump sequencer: FSM encoding, header defaults
// and the supported read-latency range.
package frame_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_A,
        ST_HDR_B,
        ST_FETCH,
        ST_SEND,
        ST_CSUM
    } state_t;

    localparam logic [7:0] HDR0_DEFAULT = 8'hA5;
    localparam logic [7:0] HDR1_DEFAULT = 8'h5A;

    // Buffer read latency may be 1..READ_LAT_MAX cycles; WAIT_W must hold READ_LAT_MAX.
    localparam int READ_LAT_MAX = 3;
    localparam int WAIT_W       = $clog2(READ_LAT_MAX + 1);

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, saturating level counter and a
// one-cycle press pulse when the counter first reaches all-ones.
module btn_debounce #(
    parameter int BITS = 14
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic press
);

    localparam logic [BITS-1:0] CNT_MAX = '1;

    logic [1:0]      sync;
    logic [BITS-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchroniser resets high and the counter saturated: a button held through reset never fires.
            sync  <= 2'b11;
            cnt   <= CNT_MAX;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], level};
            press <= 1'b0;
            if (!sync[1]) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt   <= cnt + 1'b1;
                press <= (cnt == CNT_MAX - 1'b1);
            end
        end
    end

endmodule

// File: rtl/frame_dump_ctrl.sv
// Frame buffer snapshot dumper: header, raster-order pixels, additive checksum,
// paced to the uart by an idle-gap holdoff counter.
module frame_dump_ctrl
    import frame_dump_pkg::*;
#(
    parameter int         WIDTH         = 40,
    parameter int         HEIGHT        = 30,
    parameter int         XW            = 6,
    parameter int         YW            = 5,
    parameter int         READ_LAT      = 1,
    parameter int         HOLDOFF_BITS  = 13,
    parameter int         DEBOUNCE_BITS = 14,
    parameter logic [7:0] HDR0          = HDR0_DEFAULT,
    parameter logic [7:0] HDR1          = HDR1_DEFAULT
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          trigger_i,
    input  logic          start_i,
    output logic [XW-1:0] read_x,
    output logic [YW-1:0] read_y,
    input  logic [7:0]    read_q,
    input  logic          uart_busy_i,
    output logic          uart_wr_o,
    output logic [7:0]    uart_dat_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [XW-1:0]     X_LAST    = XW'(WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(HEIGHT - 1);
    localparam logic [WAIT_W-1:0] WAIT_DONE = WAIT_W'(READ_LAT);

    state_t                  state, state_next;
    logic                    press, start, can_send;
    logic [HOLDOFF_BITS-1:0] hold;
    logic [WAIT_W-1:0]       wait_cnt, wait_next;
    logic [7:0]              csum, csum_next, dat_next;
    logic [XW-1:0]           x_next;
    logic [YW-1:0]           y_next;
    logic                    wr_next, busy_next, done_next;

    btn_debounce #(.BITS(DEBOUNCE_BITS)) u_debounce (
        .clk   (sys_clk_i),
        .rst   (sys_rst_i),
        .level (trigger_i),
        .press (press)
    );

    assign start    = press | start_i;
    assign can_send = (&hold) & ~uart_busy_i & ~uart_wr_o;

    // Idle-gap timer: any uart activity restarts the wait before the next byte.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            hold <= '0;
        end else if (uart_busy_i || uart_wr_o) begin
            hold <= '0;
        end else if (!(&hold)) begin
            hold <= hold + 1'b1;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        x_next     = read_x;
        y_next     = read_y;
        wait_next  = wait_cnt;
        csum_next  = csum;
        dat_next   = uart_dat_o;
        wr_next    = 1'b0;
        done_next  = 1'b0;
        busy_next  = busy_o;

        case (state)
            ST_IDLE: begin
                busy_next = 1'b0;
                if (start) begin
                    x_next     = '0;
                    y_next     = '0;
                    csum_next  = '0;
                    busy_next  = 1'b1;
                    state_next = ST_HDR_A;
                end
            end
            ST_HDR_A: begin
                if (can_send) begin
                    wr_next    = 1'b1;
                    dat_next   = HDR0;
                    state_next = ST_HDR_B;
                end
            end
            ST_HDR_B: begin
                if (can_send) begin
                    wr_next    = 1'b1;
                    dat_next   = HDR1;
                    wait_next  = '0;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (wait_cnt == WAIT_DONE) begin
                    dat_next   = read_q;
                    state_next = ST_SEND;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end
            ST_SEND: begin
                if (can_send) begin
                    wr_next   = 1'b1;
                    csum_next = csum + uart_dat_o;
                    wait_next = '0;
                    if (read_x == X_LAST && read_y == Y_LAST) begin
                        state_next = ST_CSUM;
                    end else begin
                        if (read_x == X_LAST) begin
                            x_next = '0;
                            y_next = read_y + 1'b1;
                        end else begin
                            x_next = read_x + 1'b1;
                        end
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_CSUM: begin
                if (can_send) begin
                    wr_next    = 1'b1;
                    dat_next   = csum;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it only takes effect on a clock edge.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state      <= ST_IDLE;
            read_x     <= '0;
            read_y     <= '0;
            wait_cnt   <= '0;
            csum       <= '0;
            uart_dat_o <= '0;
            uart_wr_o  <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state      <= state_next;
            read_x     <= x_next;
            read_y     <= y_next;
            wait_cnt   <= wait_next;
            csum       <= csum_next;
            uart_dat_o <= dat_next;
            uart_wr_o  <= wr_next;
            busy_o     <= busy_next;
            done_o     <= done_next;
        end
    end

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Self-checking bench for frame_dump_ctrl: buffer and uart models, write monitor,
// and a byte-stream reference built from the dump format.
module tb_frame_dump_ctrl;

    localparam int WIDTH         = 40;
    localparam int HEIGHT        = 30;
    localparam int XW            = 6;
    localparam int YW            = 5;
    localparam int READ_LAT      = 2;
    localparam int HOLDOFF_BITS  = 2;
    localparam int DEBOUNCE_BITS = 4;
    localparam int DUMP_LEN      = WIDTH * HEIGHT + 3;
    localparam int BUSY_CYC      = 10;

    logic          clk = 1'b0;
    logic          sys_rst_i;
    logic          trigger_i;
    logic          start_i;
    logic [XW-1:0] read_x;
    logic [YW-1:0] read_y;
    logic [7:0]    read_q;
    logic          uart_busy_i;
    logic          uart_wr_o;
    logic [7:0]    uart_dat_o;
    logic          busy_o;
    logic          done_o;

    int checks   = 0;
    int failures = 0;

    frame_dump_ctrl #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW), .READ_LAT(READ_LAT),
        .HOLDOFF_BITS(HOLDOFF_BITS), .DEBOUNCE_BITS(DEBOUNCE_BITS),
        .HDR0(8'hA5), .HDR1(8'h5A)
    ) dut (
        .sys_clk_i   (clk),
        .sys_rst_i   (sys_rst_i),
        .trigger_i   (trigger_i),
        .start_i     (start_i),
        .read_x      (read_x),
        .read_y      (read_y),
        .read_q      (read_q),
        .uart_busy_i (uart_busy_i),
        .uart_wr_o   (uart_wr_o),
        .uart_dat_o  (uart_dat_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    // Frame buffer with READ_LAT cycles of address-to-data latency.
    logic [7:0] pix [HEIGHT][WIDTH];
    logic [7:0] rd_pipe [READ_LAT];

    always @(posedge clk) begin
        if (int'(read_x) < WIDTH && int'(read_y) < HEIGHT)
            rd_pipe[0] <= pix[int'(read_y)][int'(read_x)];
        else
            rd_pipe[0] <= 8'h00;
        for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign read_q = rd_pipe[READ_LAT-1];

    // Uart model: optionally busy for BUSY_CYC cycles starting one cycle after each write.
    logic busy_en = 1'b0;
    int   busy_cnt = 0;
    always @(posedge clk) begin
        if (uart_wr_o === 1'b1 && busy_en) busy_cnt <= BUSY_CYC;
        else if (busy_cnt > 0)             busy_cnt <= busy_cnt - 1;
    end
    assign uart_busy_i = (busy_cnt > 0);

    // Write monitor.
    int         cyc = 0;
    logic [7:0] wr_q[$];
    int         wr_cyc_q[$];
    int         done_cnt = 0;
    int         done_idx = 0;
    logic       done_with_wr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (uart_wr_o === 1'b1) begin
            wr_q.push_back(uart_dat_o);
            wr_cyc_q.push_back(cyc);
        end
        if (done_o === 1'b1) begin
            done_cnt++;
            done_idx     = wr_q.size();
            done_with_wr = uart_wr_o;
        end
    end

    // Reference byte stream for the current buffer contents.
    logic [7:0] exp_q[$];

    task automatic build_expected();
        int sum = 0;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        for (int y = 0; y < HEIGHT; y++)
            for (int x = 0; x < WIDTH; x++) begin
                exp_q.push_back(pix[y][x]);
                sum += int'(pix[y][x]);
            end
        exp_q.push_back(8'(sum % 256));
    endtask

    task automatic fill_random();
        for (int y = 0; y < HEIGHT; y++)
            for (int x = 0; x < WIDTH; x++) pix[y][x] = 8'($urandom);
        build_expected();
    endtask

    task automatic pulse_start();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int budget, input string name);
        int c = 0;
        while (done_cnt == prev && c < budget) begin
            @(negedge clk); #1;
            c++;
        end
        checks++;
        if (done_cnt == prev) begin
            failures++;
            $display("FAIL %s_timeout: done_o not seen within %0d cycles", name, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_dump(input int base, input string name);
        int n = wr_q.size() - base;
        int bad = 0;
        int first = -1;
        int min_gap = 1 << 30;
        checks++;
        if (n != DUMP_LEN) begin
            failures++;
            $display("FAIL %s_count: got %0d writes expected %0d", name, n, DUMP_LEN);
        end
        for (int i = 0; i < DUMP_LEN && i < n; i++)
            if (wr_q[base+i] !== exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s_bytes: %0d wrong, first at %0d got %02h expected %02h",
                     name, bad, first, wr_q[base+first], exp_q[first]);
        end
        checks++;
        if (done_idx - base != DUMP_LEN || done_with_wr !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_pos: got write %0d (wr=%b) expected write %0d with wr=1",
                     name, done_idx - base, done_with_wr, DUMP_LEN);
        end
        for (int i = base + 1; i < wr_q.size(); i++)
            if (wr_cyc_q[i] - wr_cyc_q[i-1] < min_gap) min_gap = wr_cyc_q[i] - wr_cyc_q[i-1];
        checks++;
        if (min_gap < (1 << HOLDOFF_BITS)) begin
            failures++;
            $display("FAIL %s_gap: got min gap %0d expected >= %0d", name, min_gap, 1 << HOLDOFF_BITS);
        end
    endtask

    task automatic test_reset();
        int base;
        int busy_seen = 0;
        trigger_i = 1'b1;
        sys_rst_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (uart_wr_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: got wr=%b done=%b expected 0 0", uart_wr_o, done_o);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b expected 0", busy_o);
        end
        checks++;
        if (uart_dat_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_dat: got %02h expected 00", uart_dat_o);
        end
        checks++;
        if (read_x !== '0 || read_y !== '0) begin
            failures++;
            $display("FAIL reset_addr: got (%0d,%0d) expected (0,0)", read_x, read_y);
        end
        base = wr_q.size();
        sys_rst_i = 1'b0;
        repeat (4 * (1 << DEBOUNCE_BITS)) begin
            @(negedge clk);
            if (busy_o !== 1'b0) busy_seen++;
        end
        checks++;
        if (wr_q.size() != base || busy_seen != 0) begin
            failures++;
            $display("FAIL held_at_reset: got %0d writes %0d busy cycles expected 0 0",
                     wr_q.size() - base, busy_seen);
        end
        trigger_i = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_trigger();
        int base = wr_q.size();
        int prev = done_cnt;
        fill_random();
        @(negedge clk);
        trigger_i = 1'b1;
        repeat ((1 << DEBOUNCE_BITS) + 10) @(negedge clk);
        trigger_i = 1'b0;
        wait_done(prev, 10000, "trigger");
        check_dump(base, "trigger");
        checks++;
        if (wr_q.size() > base + 1 && (wr_q[base] !== 8'hA5 || wr_q[base+1] !== 8'h5A)) begin
            failures++;
            $display("FAIL trigger_header: got %02h %02h expected a5 5a", wr_q[base], wr_q[base+1]);
        end
        repeat (50) @(negedge clk);
        checks++;
        if (done_cnt != prev + 1) begin
            failures++;
            $display("FAIL trigger_one_dump: got %0d dumps expected 1", done_cnt - prev);
        end
    endtask

    task automatic test_pixels();
        int base = wr_q.size();
        int prev = done_cnt;
        int ramp_sum = (HEIGHT * WIDTH * (WIDTH - 1) / 2 + 4 * WIDTH * HEIGHT * (HEIGHT - 1) / 2) % 256;
        for (int y = 0; y < HEIGHT; y++)
            for (int x = 0; x < WIDTH; x++) pix[y][x] = 8'(x + 4 * y);
        build_expected();
        repeat ($urandom_range(0, 20)) @(negedge clk);
        pulse_start();
        wait_done(prev, 10000, "ramp");
        check_dump(base, "ramp");
        checks++;
        if (wr_q.size() >= base + DUMP_LEN && int'(wr_q[base+DUMP_LEN-1]) !== ramp_sum) begin
            failures++;
            $display("FAIL ramp_checksum: got %02h expected %02h", wr_q[base+DUMP_LEN-1], ramp_sum);
        end
    endtask

    task automatic test_glitch();
        int base = wr_q.size();
        int busy_seen = 0;
        for (int p = 0; p < 40; p++) begin
            trigger_i = 1'b1;
            repeat ($urandom_range(1, (1 << DEBOUNCE_BITS) - 6)) begin
                @(negedge clk);
                if (busy_o !== 1'b0) busy_seen++;
            end
            trigger_i = 1'b0;
            repeat ($urandom_range(1, 6)) begin
                @(negedge clk);
                if (busy_o !== 1'b0) busy_seen++;
            end
        end
        repeat (40) @(negedge clk);
        checks++;
        if (wr_q.size() != base || busy_seen != 0) begin
            failures++;
            $display("FAIL glitch_no_dump: got %0d writes %0d busy cycles expected 0 0",
                     wr_q.size() - base, busy_seen);
        end
    endtask

    task automatic test_start_spam();
        int base = wr_q.size();
        int prev = done_cnt;
        int busy_low = 0;
        bit seen = 0;
        fill_random();
        pulse_start();
        for (int c = 0; c < 10000 && !seen; c++) begin
            if (busy_o !== 1'b1) busy_low++;
            if (done_o === 1'b1) begin
                seen = 1;
                start_i = 1'b0;
            end else begin
                start_i = (c % 100 == 99);
                @(negedge clk);
            end
        end
        start_i = 1'b0;
        checks++;
        if (!seen || busy_low != 0) begin
            failures++;
            $display("FAIL spam_busy: got done_seen=%0d busy_low_cycles=%0d expected 1 0", seen, busy_low);
        end
        repeat (200) @(negedge clk);
        check_dump(base, "spam");
        checks++;
        if (done_cnt != prev + 1) begin
            failures++;
            $display("FAIL spam_one_dump: got %0d dumps expected 1", done_cnt - prev);
        end
    endtask

    task automatic test_busy_uart();
        int base = wr_q.size();
        int prev = done_cnt;
        int min_gap = 1 << 30;
        fill_random();
        busy_en = 1'b1;
        pulse_start();
        wait_done(prev, 25000, "busy_uart");
        busy_en = 1'b0;
        repeat (BUSY_CYC + 5) @(negedge clk);
        check_dump(base, "busy_uart");
        for (int i = base + 1; i < wr_q.size(); i++)
            if (wr_cyc_q[i] - wr_cyc_q[i-1] < min_gap) min_gap = wr_cyc_q[i] - wr_cyc_q[i-1];
        checks++;
        if (min_gap < BUSY_CYC + (1 << HOLDOFF_BITS)) begin
            failures++;
            $display("FAIL busy_uart_gap: got min gap %0d expected >= %0d",
                     min_gap, BUSY_CYC + (1 << HOLDOFF_BITS));
        end
    endtask

    task automatic test_reset_mid();
        int base = wr_q.size();
        int prev;
        int at_rst;
        int c = 0;
        fill_random();
        pulse_start();
        while (wr_q.size() - base < 500 && c < 5000) begin
            @(negedge clk); #1;
            c++;
        end
        checks++;
        if (wr_q.size() - base != 500) begin
            failures++;
            $display("FAIL rst_mid_reach: got %0d writes expected 500", wr_q.size() - base);
        end
        sys_rst_i = 1'b1;
        at_rst = wr_q.size();
        @(posedge clk); #1;
        checks++;
        if (uart_wr_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got wr=%b busy=%b expected 0 0", uart_wr_o, busy_o);
        end
        repeat (2) @(negedge clk);
        sys_rst_i = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (wr_q.size() != at_rst) begin
            failures++;
            $display("FAIL rst_mid_quiet: got %0d writes after reset expected 0", wr_q.size() - at_rst);
        end
        base = wr_q.size();
        prev = done_cnt;
        pulse_start();
        wait_done(prev, 10000, "rst_restart");
        check_dump(base, "rst_restart");
    endtask

    initial begin
        sys_rst_i = 1'b1;
        trigger_i = 1'b0;
        start_i   = 1'b0;
        test_reset();
        test_trigger();
        test_pixels();
        test_glitch();
        test_start_spam();
        test_busy_uart();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
